// File: rtl/bus_pkg.sv
// Shared types and constants for the bus slave endpoint: FSM state encoding,
// command/status codes and the field positions of the command/status words.
package bus_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_C_ACK,
    S_D_WAIT,
    S_D_ACK,
    S_EXEC,
    S_CAPT,
    S_RS_WAIT,
    S_RS_ACK,
    S_RD_WAIT,
    S_RD_ACK,
    S_SKIP
  } bus_state_e;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_BAD_REG = 8'h01;
  localparam logic [7:0] STAT_BAD_CMD = 8'h02;

  // Byte lanes shared by the command word and the status word.
  localparam int F_ADDR_LSB = 24;
  localparam int F_REG_LSB  = 16;
  localparam int F_CODE_LSB = 8;
  localparam int F_RSVD_LSB = 0;

  function automatic logic [7:0] reg_field(input logic [31:0] w);
    return w[F_REG_LSB +: 8];
  endfunction

  function automatic logic [7:0] code_field(input logic [31:0] w);
    return w[F_CODE_LSB +: 8];
  endfunction

  function automatic logic [31:0] make_status(input logic [7:0] slave,
                                              input logic [7:0] reg_num,
                                              input logic [7:0] code);
    logic [31:0] w;
    w = '0;
    w[F_ADDR_LSB +: 8] = slave;
    w[F_REG_LSB +: 8]  = reg_num;
    w[F_CODE_LSB +: 8] = code;
    return w;
  endfunction

endpackage

// File: rtl/bus_cmd_decode.sv
// Combinational command-word decoder: address match, register range check,
// command check and the resulting status code. An unknown command is reported
// ahead of a bad register number, since the register field means nothing then.
module bus_cmd_decode
  import bus_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR = 8'h01,
  parameter int         NUM_REGS   = 8
) (
  input  logic [31:0] cmd_word,
  output logic        addr_match,
  output logic        reg_valid,
  output logic        cmd_valid,
  output logic [7:0]  status
);

  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  logic [7:0] addr_f;
  logic [7:0] reg_f;
  logic [7:0] code_f;
  logic [7:0] unused_reserved;

  assign addr_f          = cmd_word[F_ADDR_LSB +: 8];
  assign reg_f           = reg_field(cmd_word);
  assign code_f          = code_field(cmd_word);
  assign unused_reserved = cmd_word[F_RSVD_LSB +: 8];

  assign addr_match = (addr_f == SLAVE_ADDR);
  assign reg_valid  = ({1'b0, reg_f} < NUM_REGS_W);
  assign cmd_valid  = (code_f == CMD_READ) || (code_f == CMD_WRITE);

  // Status code with command errors taking precedence over register errors.
  always_comb begin
    status = STAT_OK;
    if (!cmd_valid) begin
      status = STAT_BAD_CMD;
    end else if (!reg_valid) begin
      status = STAT_BAD_REG;
    end
  end

endmodule

// File: rtl/bus_slave_interface.sv
// 32-bit bus slave endpoint. Each transaction is cmd word + data word (master
// writes), then status word + data word (master reads), each word a four-phase
// req/ack handshake. One local register access is performed per transaction.
// Optional watchdog: define BUS_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a command word
// S_C_ACK   | acking command word, waiting for req low
// S_D_WAIT  | waiting for data word
// S_D_ACK   | acking data word, waiting for req low
// S_EXEC    | register strobe cycle (reg_wr / reg_rd / none on error)
// S_CAPT    | capture read data, form status word
// S_RS_WAIT | waiting for status-word read request
// S_RS_ACK  | driving status word, waiting for req low
// S_RD_WAIT | waiting for data-word read request
// S_RD_ACK  | driving data word, waiting for req low
// S_SKIP    | not addressed: count req falling edges silently
module bus_slave_interface
  import bus_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR     = 8'h01,
  parameter int         NUM_REGS       = 8,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_req,
  input  logic        bus_rw,
  input  logic [31:0] bus_data_in,
  output logic        bus_ack,
  output logic [31:0] bus_data_out,
  output logic        bus_data_oe,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wr_data,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic [31:0] reg_rd_data,
  output logic        bus_error
);

  bus_state_e  state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] data_q, data_d;
  logic [31:0] reply_q, reply_d;
  logic [31:0] status_word_q, status_word_d;
  logic [1:0]  skip_cnt_q, skip_cnt_d;
  logic        req_prev_q;
  logic        bus_ack_q, bus_ack_d;
  logic [31:0] bus_data_out_q, bus_data_out_d;
  logic        bus_data_oe_q, bus_data_oe_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_wr_data_q, reg_wr_data_d;
  logic        reg_wr_q, reg_wr_d;
  logic        reg_rd_q, reg_rd_d;
  logic        bus_error_q, bus_error_d;

  logic [31:0] dec_word;
  logic        addr_match;
  logic        reg_valid;
  logic        cmd_valid;
  logic [7:0]  dec_status;
  logic        cmd_ok;
  logic        is_write;
  logic        req_fall;
  logic        timeout;

  // In IDLE the incoming word is decoded for the address match; afterwards
  // the latched command word drives validation and the status code.
  assign dec_word = (state_q == S_IDLE) ? bus_data_in : cmd_q;

  bus_cmd_decode #(
    .SLAVE_ADDR (SLAVE_ADDR),
    .NUM_REGS   (NUM_REGS)
  ) u_decode (
    .cmd_word   (dec_word),
    .addr_match (addr_match),
    .reg_valid  (reg_valid),
    .cmd_valid  (cmd_valid),
    .status     (dec_status)
  );

  assign cmd_ok   = cmd_valid && reg_valid;
  assign is_write = (code_field(cmd_q) == CMD_WRITE);
  assign req_fall = req_prev_q && !bus_req;

`ifdef BUS_TIMEOUT_EN
  localparam logic [15:0] WD_LOAD = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_q, wd_d;

  assign timeout = (state_q != S_IDLE) && (wd_q == 16'd0);

  // Watchdog down-counter: reloads on every state change and while idle.
  always_comb begin
    wd_d = WD_LOAD;
    if ((state_q != S_IDLE) && (state_d == state_q)) begin
      wd_d = wd_q - 16'd1;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q <= WD_LOAD;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cmd_q          <= '0;
      data_q         <= '0;
      reply_q        <= '0;
      status_word_q  <= '0;
      skip_cnt_q     <= '0;
      req_prev_q     <= 1'b0;
      bus_ack_q      <= 1'b0;
      bus_data_out_q <= '0;
      bus_data_oe_q  <= 1'b0;
      reg_addr_q     <= '0;
      reg_wr_data_q  <= '0;
      reg_wr_q       <= 1'b0;
      reg_rd_q       <= 1'b0;
      bus_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      data_q         <= data_d;
      reply_q        <= reply_d;
      status_word_q  <= status_word_d;
      skip_cnt_q     <= skip_cnt_d;
      req_prev_q     <= bus_req;
      bus_ack_q      <= bus_ack_d;
      bus_data_out_q <= bus_data_out_d;
      bus_data_oe_q  <= bus_data_oe_d;
      reg_addr_q     <= reg_addr_d;
      reg_wr_data_q  <= reg_wr_data_d;
      reg_wr_q       <= reg_wr_d;
      reg_rd_q       <= reg_rd_d;
      bus_error_q    <= bus_error_d;
    end
  end

  // Next-state logic plus latching of the two master-written words.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    skip_cnt_d = skip_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus_req && bus_rw) begin
          cmd_d      = bus_data_in;
          skip_cnt_d = 2'd3;
          state_d    = addr_match ? S_C_ACK : S_SKIP;
        end
      end
      S_C_ACK:   if (!bus_req) state_d = S_D_WAIT;
      S_D_WAIT: begin
        if (bus_req && bus_rw) begin
          data_d  = bus_data_in;
          state_d = S_D_ACK;
        end
      end
      S_D_ACK:   if (!bus_req) state_d = S_EXEC;
      S_EXEC:    state_d = S_CAPT;
      S_CAPT:    state_d = S_RS_WAIT;
      S_RS_WAIT: if (bus_req && !bus_rw) state_d = S_RS_ACK;
      S_RS_ACK:  if (!bus_req) state_d = S_RD_WAIT;
      S_RD_WAIT: if (bus_req && !bus_rw) state_d = S_RD_ACK;
      S_RD_ACK:  if (!bus_req) state_d = S_IDLE;
      S_SKIP: begin
        // The command word's own fall is the first of four.
        if (req_fall) begin
          if (skip_cnt_q == 2'd0) begin
            state_d = S_IDLE;
          end else begin
            skip_cnt_d = skip_cnt_q - 2'd1;
          end
        end
      end
      default:   state_d = S_IDLE;
    endcase
    if (timeout) begin
      state_d = S_IDLE;
    end
  end

  // Registered outputs derived from the upcoming state, so ack/oe/data change
  // on the same edge that the FSM takes the transition.
  always_comb begin
    bus_ack_d      = (state_d == S_C_ACK) || (state_d == S_D_ACK) ||
                     (state_d == S_RS_ACK) || (state_d == S_RD_ACK);
    bus_data_oe_d  = (state_d == S_RS_ACK) || (state_d == S_RD_ACK);
    bus_data_out_d = '0;
    if (state_d == S_RS_ACK) begin
      bus_data_out_d = status_word_q;
    end else if (state_d == S_RD_ACK) begin
      bus_data_out_d = reply_q;
    end

    reg_wr_d      = 1'b0;
    reg_rd_d      = 1'b0;
    reg_addr_d    = reg_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    bus_error_d   = bus_error_q;
    status_word_d = status_word_q;
    reply_d       = reply_q;

    // Strobe is issued for the S_EXEC cycle so read data lands in S_CAPT.
    if ((state_q == S_D_ACK) && (state_d == S_EXEC)) begin
      bus_error_d = !cmd_ok;
      if (cmd_ok) begin
        reg_addr_d = reg_field(cmd_q);
        if (is_write) begin
          reg_wr_d      = 1'b1;
          reg_wr_data_d = data_q;
        end else begin
          reg_rd_d = 1'b1;
        end
      end
    end

    if (state_q == S_CAPT) begin
      status_word_d = make_status(SLAVE_ADDR, reg_field(cmd_q), dec_status);
      if (!cmd_ok) begin
        reply_d = '0;
      end else if (is_write) begin
        reply_d = data_q;
      end else begin
        reply_d = reg_rd_data;
      end
    end

    if (timeout) begin
      bus_error_d = 1'b1;
    end
  end

  assign bus_ack      = bus_ack_q;
  assign bus_data_out = bus_data_out_q;
  assign bus_data_oe  = bus_data_oe_q;
  assign reg_addr     = reg_addr_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign reg_wr       = reg_wr_q;
  assign reg_rd       = reg_rd_q;
  assign bus_error    = bus_error_q;

endmodule

// File: tb/tb_bus_slave_interface.sv
// Directed bench for bus_slave_interface: a table of full transactions plus
// hand sequences for address mismatch, wrong direction, async reset and stall.
module tb_bus_slave_interface;
  import bus_pkg::*;

  logic        clk;
  logic        reset;
  logic        bus_req;
  logic        bus_rw;
  logic [31:0] bus_data_in;
  logic        bus_ack;
  logic [31:0] bus_data_out;
  logic        bus_data_oe;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rd_data;
  logic        bus_error;

  bus_slave_interface #(
    .SLAVE_ADDR     (8'h01),
    .NUM_REGS       (8),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus_req      (bus_req),
    .bus_rw       (bus_rw),
    .bus_data_in  (bus_data_in),
    .bus_ack      (bus_ack),
    .bus_data_out (bus_data_out),
    .bus_data_oe  (bus_data_oe),
    .reg_addr     (reg_addr),
    .reg_wr_data  (reg_wr_data),
    .reg_wr       (reg_wr),
    .reg_rd       (reg_rd),
    .reg_rd_data  (reg_rd_data),
    .bus_error    (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Strobe/ack monitor and register-bank responder (data valid 1 cycle after reg_rd).
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          ack_cnt = 0;
  int          oe_cnt = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [31:0] last_wr_data = 32'h0;
  logic [31:0] rd_value = 32'h0;
  logic        rd_pend = 1'b0;

  always @(posedge clk) begin
    #1;
    if (reg_wr) begin
      wr_cnt++;
      last_addr    = reg_addr;
      last_wr_data = reg_wr_data;
    end
    if (reg_rd) begin
      rd_cnt++;
      last_addr = reg_addr;
    end
    if (bus_ack) ack_cnt++;
    if (bus_data_oe) oe_cnt++;
    reg_rd_data = rd_pend ? rd_value : 32'hBAD0_BAD0;
    rd_pend     = reg_rd;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic v, input string nm);
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus_ack !== v && n < 20);
    chk(nm, 32'(bus_ack), 32'(v));
  endtask

  task automatic bus_write(input logic [31:0] w);
    bus_req     = 1'b1;
    bus_rw      = 1'b1;
    bus_data_in = w;
    wait_ack(1'b1, "wr_ack_rise");
    bus_req     = 1'b0;
    bus_data_in = 32'h0;
    wait_ack(1'b0, "wr_ack_fall");
  endtask

  task automatic bus_read(output logic [31:0] w);
    bus_req = 1'b1;
    bus_rw  = 1'b0;
    wait_ack(1'b1, "rd_ack_rise");
    w = bus_data_out;
    chk("rd_oe_with_ack", 32'(bus_data_oe), 32'd1);
    bus_req = 1'b0;
    wait_ack(1'b0, "rd_ack_fall");
    chk("rd_oe_drop", 32'(bus_data_oe), 32'd0);
  endtask

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] data;
    logic [31:0] rd_val;
    logic [31:0] exp_status;
    logic [31:0] exp_data;
    int          exp_wr;
    int          exp_rd;
    logic [7:0]  exp_addr;
    logic        exp_err;
  } vec_t;

  localparam int NV = 8;
  vec_t vt[NV];

  logic [31:0] st;
  logic [31:0] dt;
  int          wr0;
  int          rd0;

  task automatic run_vec(input int i);
    rd_value = vt[i].rd_val;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    bus_write(vt[i].cmd);
    bus_write(vt[i].data);
    bus_read(st);
    bus_read(dt);
    chk($sformatf("v%0d_status", i), st, vt[i].exp_status);
    chk($sformatf("v%0d_data", i), dt, vt[i].exp_data);
    chk($sformatf("v%0d_wr_pulses", i), 32'(wr_cnt - wr0), 32'(vt[i].exp_wr));
    chk($sformatf("v%0d_rd_pulses", i), 32'(rd_cnt - rd0), 32'(vt[i].exp_rd));
    if (vt[i].exp_wr + vt[i].exp_rd > 0)
      chk($sformatf("v%0d_reg_addr", i), 32'(last_addr), 32'(vt[i].exp_addr));
    if (vt[i].exp_wr > 0)
      chk($sformatf("v%0d_reg_wr_data", i), last_wr_data, vt[i].data);
    chk($sformatf("v%0d_bus_error", i), 32'(bus_error), 32'(vt[i].exp_err));
  endtask

  initial begin
    vt[0] = '{32'h01_03_02_00, 32'hDEAD_BEEF, 32'h0,         32'h01_03_00_00, 32'hDEAD_BEEF, 1, 0, 8'd3, 1'b0};
    vt[1] = '{32'h01_05_01_00, 32'hCAFE_F00D, 32'h1234_5678, 32'h01_05_00_00, 32'h1234_5678, 0, 1, 8'd5, 1'b0};
    vt[2] = '{32'h01_09_01_00, 32'h1111_2222, 32'h7777_7777, 32'h01_09_01_00, 32'h0,         0, 0, 8'd0, 1'b1};
    vt[3] = '{32'h01_07_02_00, 32'h0000_00A5, 32'h0,         32'h01_07_00_00, 32'h0000_00A5, 1, 0, 8'd7, 1'b0};
    vt[4] = '{32'h01_02_05_00, 32'h1111_1111, 32'h0,         32'h01_02_02_00, 32'h0,         0, 0, 8'd0, 1'b1};
    vt[5] = '{32'h01_00_01_00, 32'h0,         32'h0F0F_0F0F, 32'h01_00_00_00, 32'h0F0F_0F0F, 0, 1, 8'd0, 1'b0};
    vt[6] = '{32'h01_08_02_00, 32'h3333_3333, 32'h0,         32'h01_08_01_00, 32'h0,         0, 0, 8'd0, 1'b1};
    vt[7] = '{32'h01_01_02_FF, 32'h5555_AAAA, 32'h0,         32'h01_01_00_00, 32'h5555_AAAA, 1, 0, 8'd1, 1'b0};

    reset       = 1'b0;
    bus_req     = 1'b0;
    bus_rw      = 1'b0;
    bus_data_in = 32'h0;
    repeat (3) tick();
    chk("rst_bus_ack", 32'(bus_ack), 32'd0);
    chk("rst_data_out", bus_data_out, 32'd0);
    chk("rst_data_oe", 32'(bus_data_oe), 32'd0);
    chk("rst_reg_wr", 32'(reg_wr), 32'd0);
    chk("rst_reg_rd", 32'(reg_rd), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_reg_wr_data", reg_wr_data, 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
    reset = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < NV; i++) begin
      run_vec(i);
    end

    // Address mismatch: four handshakes acked by some other slave.
    ack_cnt = 0;
    oe_cnt  = 0;
    wr0     = wr_cnt;
    rd0     = rd_cnt;
    for (int h = 0; h < 4; h++) begin
      bus_req     = 1'b1;
      bus_rw      = (h < 2);
      bus_data_in = (h == 0) ? 32'h07_00_01_00 : 32'h9999_9999;
      repeat (2) tick();
      bus_req     = 1'b0;
      bus_data_in = 32'h0;
      repeat (2) tick();
      if (h == 2) chk("skip_after_3_falls", 32'(dut.state_q), 32'(S_SKIP));
    end
    chk("skip_idle_after_4_falls", 32'(dut.state_q), 32'(S_IDLE));
    chk("skip_ack_cycles", 32'(ack_cnt), 32'd0);
    chk("skip_oe_cycles", 32'(oe_cnt), 32'd0);
    chk("skip_strobes", 32'(wr_cnt - wr0 + rd_cnt - rd0), 32'd0);

    // Wrong direction in a wait state is ignored.
    rd_value = 32'hA5A5_0001;
    bus_write(32'h01_04_01_00);
    bus_req = 1'b1;
    bus_rw  = 1'b0;
    repeat (4) tick();
    chk("wrongdir_dwait_ack", 32'(bus_ack), 32'd0);
    chk("wrongdir_dwait_state", 32'(dut.state_q), 32'(S_D_WAIT));
    bus_req = 1'b0;
    tick();
    bus_write(32'h0);
    bus_req     = 1'b1;
    bus_rw      = 1'b1;
    bus_data_in = 32'hFFFF_FFFF;
    repeat (6) tick();
    chk("wrongdir_rswait_ack", 32'(bus_ack), 32'd0);
    chk("wrongdir_rswait_state", 32'(dut.state_q), 32'(S_RS_WAIT));
    bus_req     = 1'b0;
    bus_data_in = 32'h0;
    tick();
    bus_read(st);
    bus_read(dt);
    chk("wrongdir_status", st, 32'h01_04_00_00);
    chk("wrongdir_data", dt, 32'hA5A5_0001);

    // Async reset while driving the status word.
    bus_write(32'h01_06_02_00);
    bus_write(32'h0BAD_F00D);
    bus_req = 1'b1;
    bus_rw  = 1'b0;
    wait_ack(1'b1, "rsack_ack_rise");
    chk("rsack_state", 32'(dut.state_q), 32'(S_RS_ACK));
    #2 reset = 1'b0;
    #1;
    chk("async_rst_ack", 32'(bus_ack), 32'd0);
    chk("async_rst_oe", 32'(bus_data_oe), 32'd0);
    chk("async_rst_data", bus_data_out, 32'd0);
    chk("async_rst_state", 32'(dut.state_q), 32'(S_IDLE));
    bus_req = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();
    run_vec(0);

    // Stall after the command word.
    bus_write(32'h01_02_02_00);
`ifdef BUS_TIMEOUT_EN
    repeat (19) tick();
    chk("wd_before_limit", 32'(dut.state_q), 32'(S_D_WAIT));
    tick();
    chk("wd_state_idle", 32'(dut.state_q), 32'(S_IDLE));
    chk("wd_bus_error", 32'(bus_error), 32'd1);
    chk("wd_ack", 32'(bus_ack), 32'd0);
`else
    repeat (100) tick();
    chk("stall_state", 32'(dut.state_q), 32'(S_D_WAIT));
    chk("stall_ack", 32'(bus_ack), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
